// File: rtl/ccip_mmio_csr_block_if.sv
`default_nettype none
// ============================================================================
// Module      : ccip_mmio_csr_block_if
// Description : MMIO subset of the CCI-P boundary seen by the CSR block.
//               c0_* carries MMIO requests from the platform: read valid,
//               write valid, header address/length/tid and write data.
//               c2_* carries MMIO read responses: valid, tid and data.
//               The master modport is the platform side that issues
//               requests. The slave modport is the CSR block that answers.
// Revision    : 1.0 - initial release
// ============================================================================
interface ccip_mmio_csr_block_if;
    // Rx c0 : MMIO request (header address is in DWORDs)
    logic        c0_mmio_rd_valid;
    logic        c0_mmio_wr_valid;
    logic [15:0] c0_hdr_address;
    logic [1:0]  c0_hdr_length;
    logic [8:0]  c0_hdr_tid;
    logic [63:0] c0_data;
    // Tx c2 : MMIO read response
    logic        c2_mmio_rd_valid;
    logic [8:0]  c2_hdr_tid;
    logic [63:0] c2_data;

    modport master (
        output c0_mmio_rd_valid, c0_mmio_wr_valid, c0_hdr_address,
               c0_hdr_length, c0_hdr_tid, c0_data,
        input  c2_mmio_rd_valid, c2_hdr_tid, c2_data
    );

    modport slave (
        input  c0_mmio_rd_valid, c0_mmio_wr_valid, c0_hdr_address,
               c0_hdr_length, c0_hdr_tid, c0_data,
        output c2_mmio_rd_valid, c2_hdr_tid, c2_data
    );
endinterface
`default_nettype wire

// File: rtl/ccip_mmio_csr_block.sv
`default_nettype none
// ============================================================================
// Module      : ccip_mmio_csr_block
// Description : Three-stage CCI-P MMIO slave. It holds the DFH, AFU ID,
//               scratch, cycle counter, status and control CSRs, and answers
//               reads exactly three cycles after the request.
// Ports       : Clk_400         - clock (all state on its rising edge)
//               SoftReset       - synchronous active-high reset
//               ccip            - MMIO request (c0) / response (c2) bus
//               pck_cp2af_error - platform error, sets the sticky status bit
//               csr_ctrl        - registered CTRL CSR for downstream logic
// Revision    : 1.0 - initial release
// ============================================================================
module ccip_mmio_csr_block #(
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000
) (
    input  logic                         Clk_400,
    input  logic                         SoftReset,
    ccip_mmio_csr_block_if.slave         ccip,
    input  logic                         pck_cp2af_error,
    output logic [63:0]                  csr_ctrl
);

    // CSR quadword indices (byte offset / 8)
    localparam logic [14:0] QW_DFH      = 15'd0;
    localparam logic [14:0] QW_AFU_L    = 15'd1;
    localparam logic [14:0] QW_AFU_H    = 15'd2;
    localparam logic [14:0] QW_SCRATCH0 = 15'd5;
    localparam logic [14:0] QW_SCRATCH1 = 15'd6;
    localparam logic [14:0] QW_CYCLE    = 15'd7;
    localparam logic [14:0] QW_STATUS   = 15'd8;
    localparam logic [14:0] QW_CTRL     = 15'd9;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    // ---------------------------------------------------------------- stage 1
    logic        r_s1_rd;
    logic        r_s1_wr;
    logic        r_s1_err;
    logic [15:0] r_s1_addr;
    logic        r_s1_len8;
    logic [8:0]  r_s1_tid;
    logic [63:0] r_s1_data;

    // The error input rides along with stage 1 so that an error and a W1C
    // write presented in the same cycle meet on the same commit edge.
    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            r_s1_rd   <= 1'b0;
            r_s1_wr   <= 1'b0;
            r_s1_err  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_len8 <= 1'b0;
            r_s1_tid  <= '0;
            r_s1_data <= '0;
        end else begin
            r_s1_rd   <= ccip.c0_mmio_rd_valid;
            r_s1_wr   <= ccip.c0_mmio_wr_valid;
            r_s1_err  <= pck_cp2af_error;
            r_s1_addr <= ccip.c0_hdr_address;
            r_s1_len8 <= (ccip.c0_hdr_length == 2'd1);
            r_s1_tid  <= ccip.c0_hdr_tid;
            r_s1_data <= ccip.c0_data;
        end
    end

    // ---------------------------------------------------------------- decode
    logic [14:0] w_qw;
    logic        w_upper;
    logic        w_misalign;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic [31:0] w_wdata_hi;

    assign w_qw       = r_s1_addr[15:1];
    assign w_upper    = r_s1_addr[0];
    assign w_misalign = r_s1_len8 & r_s1_addr[0];
    // Which 32-bit halves of the addressed quadword a write touches
    assign w_wr_lo    = r_s1_wr & ~w_misalign & (r_s1_len8 | ~w_upper);
    assign w_wr_hi    = r_s1_wr & ~w_misalign & (r_s1_len8 |  w_upper);
    // A 4 B write to the upper half carries its payload in data[31:0]
    assign w_wdata_hi = r_s1_len8 ? r_s1_data[63:32] : r_s1_data[31:0];

    function automatic logic [63:0] merge_wr(input logic [63:0] old_val,
                                             input logic        wr_lo,
                                             input logic        wr_hi,
                                             input logic [31:0] lo_val,
                                             input logic [31:0] hi_val);
        merge_wr = {wr_hi ? hi_val : old_val[63:32],
                    wr_lo ? lo_val : old_val[31:0]};
    endfunction

    // ---------------------------------------------------------------- CSRs
    logic [63:0] r_scratch0;
    logic [63:0] r_scratch1;
    logic [63:0] r_ctrl;
    logic [63:0] r_cycle;
    logic        r_err;
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    logic        w_st_wr;
    logic        w_err_clr;
    logic        w_cnt_clr;

    // STATUS control bits live in the low half only
    assign w_st_wr   = w_wr_lo & (w_qw == QW_STATUS);
    assign w_err_clr = w_st_wr & r_s1_data[0];
    assign w_cnt_clr = w_st_wr & r_s1_data[1];

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            r_scratch0 <= '0;
            r_scratch1 <= '0;
            r_ctrl     <= '0;
            r_cycle    <= '0;
            r_err      <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            if (w_qw == QW_SCRATCH0) begin
                r_scratch0 <= merge_wr(r_scratch0, w_wr_lo, w_wr_hi,
                                       r_s1_data[31:0], w_wdata_hi);
            end
            if (w_qw == QW_SCRATCH1) begin
                r_scratch1 <= merge_wr(r_scratch1, w_wr_lo, w_wr_hi,
                                       r_s1_data[31:0], w_wdata_hi);
            end
            if (w_qw == QW_CTRL) begin
                r_ctrl <= merge_wr(r_ctrl, w_wr_lo, w_wr_hi,
                                   r_s1_data[31:0], w_wdata_hi);
            end

            // CTRL[0] freezes the counter; natural 64-bit wrap
            if (!r_ctrl[0]) begin
                r_cycle <= r_cycle + 64'd1;
            end

            // Error set takes priority over the W1C clear
            if (r_s1_err) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end

            // Clear takes priority over the increment
            if (w_cnt_clr) begin
                r_rd_cnt <= '0;
            end else if (r_s1_rd && (r_rd_cnt != CNT_MAX)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end

            if (w_cnt_clr) begin
                r_wr_cnt <= '0;
            end else if (r_s1_wr && (r_wr_cnt != CNT_MAX)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    assign csr_ctrl = r_ctrl;

    // ---------------------------------------------------------------- read mux
    logic [63:0] w_qw_val;
    logic [63:0] w_rd_data;

    always_comb begin
        w_qw_val = '0;
        case (w_qw)
            QW_DFH:      w_qw_val = DFH_VALUE;
            QW_AFU_L:    w_qw_val = AFU_ID_L;
            QW_AFU_H:    w_qw_val = AFU_ID_H;
            QW_SCRATCH0: w_qw_val = r_scratch0;
            QW_SCRATCH1: w_qw_val = r_scratch1;
            QW_CYCLE:    w_qw_val = r_cycle;
            QW_STATUS:   w_qw_val = {16'h0, r_wr_cnt, r_rd_cnt, 15'h0, r_err};
            QW_CTRL:     w_qw_val = r_ctrl;
            default:     w_qw_val = '0;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        if (!w_misalign) begin
            if (r_s1_len8) begin
                w_rd_data = w_qw_val;
            end else if (w_upper) begin
                w_rd_data = {32'h0, w_qw_val[63:32]};
            end else begin
                w_rd_data = {32'h0, w_qw_val[31:0]};
            end
        end
    end

    // ---------------------------------------------------------------- stage 2/3
    logic        r_s2_vld;
    logic [8:0]  r_s2_tid;
    logic [63:0] r_s2_data;
    logic        r_s3_vld;
    logic [8:0]  r_s3_tid;
    logic [63:0] r_s3_data;

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            r_s2_vld  <= 1'b0;
            r_s2_tid  <= '0;
            r_s2_data <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_tid  <= '0;
            r_s3_data <= '0;
        end else begin
            r_s2_vld  <= r_s1_rd;
            r_s2_tid  <= r_s1_tid;
            r_s2_data <= w_rd_data;
            r_s3_vld  <= r_s2_vld;
            r_s3_tid  <= r_s2_tid;
            r_s3_data <= r_s2_data;
        end
    end

    assign ccip.c2_mmio_rd_valid = r_s3_vld;
    assign ccip.c2_hdr_tid       = r_s3_tid;
    assign ccip.c2_data          = r_s3_data;

endmodule
`default_nettype wire

// File: tb/tb_ccip_mmio_csr_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccip_mmio_csr_block
// Description : Self-checking bench for ccip_mmio_csr_block. It applies a
//               directed vector table, multi-cycle sequences (read burst,
//               counter freeze, reset flush) and randomized traffic that is
//               checked against a register-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccip_mmio_csr_block;

    localparam logic [63:0] DFH   = 64'h1000_0000_0000_0000;
    localparam logic [63:0] AFU_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] AFU_H = 64'hFEDC_BA98_7654_3210;
    localparam int          NE    = 4096;

    logic        Clk_400 = 1'b0;
    logic        SoftReset = 1'b1;
    logic        pck_cp2af_error = 1'b0;
    logic [63:0] csr_ctrl;

    ccip_mmio_csr_block_if bus ();

    ccip_mmio_csr_block #(
        .AFU_ID_L  (AFU_L),
        .AFU_ID_H  (AFU_H),
        .DFH_VALUE (DFH)
    ) dut (
        .Clk_400         (Clk_400),
        .SoftReset       (SoftReset),
        .ccip            (bus),
        .pck_cp2af_error (pck_cp2af_error),
        .csr_ctrl        (csr_ctrl)
    );

    always #5 Clk_400 = ~Clk_400;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge Clk_400) cyc <= cyc + 1;

    // Expected responses, indexed by the cycle in which they must appear
    bit          exp_v   [NE];
    logic [8:0]  exp_tid [NE];
    logic [63:0] exp_d   [NE];
    bit          exp_dc  [NE];
    logic [63:0] got_d   [512];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Response monitor: every cycle either the scheduled response or silence
    always @(negedge Clk_400) begin
        if (mon_en && cyc < NE) begin
            n_checks++;
            if (exp_v[cyc]) begin
                if (bus.c2_mmio_rd_valid !== 1'b1 || bus.c2_hdr_tid !== exp_tid[cyc] ||
                    (!exp_dc[cyc] && bus.c2_data !== exp_d[cyc])) begin
                    n_fail++;
                    $display("FAIL resp@%0d: got valid=%b tid=%h data=%h expected valid=1 tid=%h data=%h",
                             cyc, bus.c2_mmio_rd_valid, bus.c2_hdr_tid, bus.c2_data,
                             exp_tid[cyc], exp_dc[cyc] ? 64'hx : exp_d[cyc]);
                end
                got_d[bus.c2_hdr_tid] = bus.c2_data;
            end else if (bus.c2_mmio_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle@%0d: got valid=%b tid=%h expected valid=0",
                         cyc, bus.c2_mmio_rd_valid, bus.c2_hdr_tid);
            end
        end
    end

    // One request cycle; called #1 after a rising edge, returns #1 after the next
    task automatic drive(input bit rd, input bit wr, input logic [15:0] dw, input bit l8,
                         input logic [8:0] tid, input logic [63:0] d, input bit e,
                         input bit chk_rsp, input logic [63:0] x, input bit dc);
        bus.c0_mmio_rd_valid = rd;
        bus.c0_mmio_wr_valid = wr;
        bus.c0_hdr_address   = dw;
        bus.c0_hdr_length    = l8 ? 2'd1 : 2'd0;
        bus.c0_hdr_tid       = tid;
        bus.c0_data          = d;
        pck_cp2af_error      = e;
        if (rd && chk_rsp && (cyc + 3) < NE) begin
            exp_v[cyc + 3]   = 1'b1;
            exp_tid[cyc + 3] = tid;
            exp_d[cyc + 3]   = x;
            exp_dc[cyc + 3]  = dc;
        end
        @(posedge Clk_400);
        #1;
        bus.c0_mmio_rd_valid = 1'b0;
        bus.c0_mmio_wr_valid = 1'b0;
        pck_cp2af_error      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 0, 9'h0, 64'h0, 0, 0, 64'h0, 0);
    endtask

    task automatic rd_chk(input logic [15:0] dw, input bit l8, input logic [8:0] tid, input logic [63:0] x);
        drive(1, 0, dw, l8, tid, 64'h0, 0, 1, x, 0);
    endtask

    task automatic rd_dc(input logic [15:0] dw, input logic [8:0] tid);
        drive(1, 0, dw, 1, tid, 64'h0, 0, 1, 64'h0, 1);
    endtask

    task automatic wr(input logic [15:0] dw, input bit l8, input logic [63:0] d);
        drive(0, 1, dw, l8, 9'h0, d, 0, 0, 64'h0, 0);
    endtask

    task automatic pulse_reset();
        idle(6);
        SoftReset = 1'b1;
        idle(2);
        SoftReset = 1'b0;
    endtask

    // ------------------------------------------------------------ reference model
    logic [63:0] m_s0, m_s1, m_ctrl;
    bit          m_err;
    int          m_rc, m_wc;

    task automatic m_reset();
        m_s0 = '0; m_s1 = '0; m_ctrl = '0; m_err = 0; m_rc = 0; m_wc = 0;
    endtask

    function automatic logic [63:0] m_qword(input int q);
        case (q)
            0:       return DFH;
            1:       return AFU_L;
            2:       return AFU_H;
            5:       return m_s0;
            6:       return m_s1;
            8:       return (64'(m_wc) << 32) | (64'(m_rc) << 16) | 64'(m_err);
            9:       return m_ctrl;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [15:0] dw, input bit l8);
        int          byte_off;
        logic [63:0] v;
        byte_off = int'(dw) * 4;
        v = m_qword(byte_off / 8);
        if (l8) return (byte_off % 8 != 0) ? 64'h0 : v;
        return ((byte_off / 4) % 2 == 1) ? (v >> 32) : (v & 64'hFFFF_FFFF);
    endfunction

    task automatic m_apply(input bit rd, input bit w, input logic [15:0] dw, input bit l8,
                           input logic [63:0] d, input bit e);
        int          byte_off, q;
        logic [63:0] mask, val;
        bit          clr;
        byte_off = int'(dw) * 4;
        q   = byte_off / 8;
        clr = 0;
        if (w && !(l8 && byte_off % 8 != 0)) begin
            if (l8) begin
                mask = '1; val = d;
            end else if ((byte_off / 4) % 2 == 1) begin
                mask = 64'hFFFF_FFFF_0000_0000; val = {d[31:0], 32'h0};
            end else begin
                mask = 64'h0000_0000_FFFF_FFFF; val = {32'h0, d[31:0]};
            end
            if (q == 5) m_s0   = (m_s0 & ~mask) | (val & mask);
            if (q == 6) m_s1   = (m_s1 & ~mask) | (val & mask);
            if (q == 9) m_ctrl = (m_ctrl & ~mask) | (val & mask);
            if (q == 8 && mask[0]) begin
                if (val[0]) m_err = 0;
                clr = val[1];
            end
        end
        if (rd && m_rc < 65535) m_rc++;
        if (w && m_wc < 65535) m_wc++;
        if (clr) begin m_rc = 0; m_wc = 0; end
        if (e) m_err = 1;
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] dw;
        bit          l8;
        logic [63:0] d;
        bit          e;
        logic [63:0] x;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1, 0, 16'h0000, 1, 64'h0, 0, DFH});
        tbl.push_back('{1, 0, 16'h0002, 1, 64'h0, 0, AFU_L});
        tbl.push_back('{1, 0, 16'h0004, 1, 64'h0, 0, AFU_H});
        tbl.push_back('{0, 1, 16'h000A, 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0});
        tbl.push_back('{0, 1, 16'h000B, 0, 64'hFFFF_FFFF_1234_5678, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h000A, 1, 64'h0, 0, 64'h1234_5678_CAFE_F00D});
        tbl.push_back('{1, 0, 16'h000B, 0, 64'h0, 0, 64'h0000_0000_1234_5678});
        tbl.push_back('{1, 0, 16'h000A, 0, 64'h0, 0, 64'h0000_0000_CAFE_F00D});
        tbl.push_back('{1, 0, 16'h000B, 1, 64'h0, 0, 64'h0});
        tbl.push_back('{0, 1, 16'h000B, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h000A, 1, 64'h0, 0, 64'h1234_5678_CAFE_F00D});
        tbl.push_back('{0, 1, 16'h0000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0000, 1, 64'h0, 0, DFH});
        tbl.push_back('{1, 0, 16'h0040, 1, 64'h0, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0006, 1, 64'h0, 0, 64'h0});
        tbl.push_back('{0, 1, 16'h0012, 1, 64'hA5A5_0000_0000_0002, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0012, 1, 64'h0, 0, 64'hA5A5_0000_0000_0002});
        tbl.push_back('{0, 1, 16'h0013, 0, 64'h0000_0000_0000_0011, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0012, 1, 64'h0, 0, 64'h0000_0011_0000_0002});
        tbl.push_back('{0, 0, 16'h0000, 0, 64'h0, 1, 64'h0});
        tbl.push_back('{1, 0, 16'h0010, 1, 64'h0, 0, 64'h0000_0006_000D_0001});
        tbl.push_back('{0, 1, 16'h0010, 1, 64'h1, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0010, 1, 64'h0, 0, 64'h0000_0007_000E_0000});
        tbl.push_back('{0, 1, 16'h0010, 1, 64'h1, 1, 64'h0});
        tbl.push_back('{1, 0, 16'h0010, 1, 64'h0, 0, 64'h0000_0008_000F_0001});
        tbl.push_back('{0, 1, 16'h0010, 0, 64'h2, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0010, 1, 64'h0, 0, 64'h0000_0000_0000_0001});
        tbl.push_back('{0, 1, 16'h0010, 1, 64'h3, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0010, 1, 64'h0, 0, 64'h0});
        tbl.push_back('{1, 0, 16'h0010, 0, 64'h0, 0, 64'h0000_0000_0001_0000});

        bus.c0_mmio_rd_valid = 1'b0;
        bus.c0_mmio_wr_valid = 1'b0;
        bus.c0_hdr_address   = '0;
        bus.c0_hdr_length    = '0;
        bus.c0_hdr_tid       = '0;
        bus.c0_data          = '0;
        for (int i = 0; i < 512; i++) got_d[i] = '0;

        // Reset state
        repeat (3) @(posedge Clk_400);
        #1;
        chk("reset_rd_valid", 64'(bus.c2_mmio_rd_valid), 64'h0);
        chk("reset_tid",      64'(bus.c2_hdr_tid), 64'h0);
        chk("reset_data",     bus.c2_data, 64'h0);
        chk("reset_csr_ctrl", csr_ctrl, 64'h0);
        SoftReset = 1'b0;
        mon_en    = 1'b1;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].dw, tbl[i].l8,
                  (i < 3) ? 9'h1A5 : 9'(i), tbl[i].d, tbl[i].e, 1, tbl[i].x, 0);
        end
        idle(4);
        chk("csr_ctrl_after_table", csr_ctrl, 64'h0000_0011_0000_0002);

        // 64 back-to-back reads
        wr(16'h0010, 1, 64'h2);
        for (int i = 0; i < 64; i++) rd_chk(16'h000A, 1, 9'(9'h100 + i), 64'h1234_5678_CAFE_F00D);
        rd_chk(16'h0010, 1, 9'h077, 64'h0000_0000_0040_0000);
        idle(4);

        // Counter freeze and release
        wr(16'h0012, 1, 64'h1);
        idle(2);
        rd_dc(16'h000E, 9'h030);
        idle(9);
        rd_dc(16'h000E, 9'h031);
        idle(5);
        chk("cycle_cnt_frozen", got_d[9'h031], got_d[9'h030]);
        chk("csr_ctrl_freeze", csr_ctrl, 64'h1);
        wr(16'h0012, 1, 64'h0);
        idle(2);
        rd_dc(16'h000E, 9'h032);
        idle(9);
        rd_dc(16'h000E, 9'h033);
        idle(5);
        chk("cycle_cnt_delta", got_d[9'h033] - got_d[9'h032], 64'd10);
        chk("csr_ctrl_release", csr_ctrl, 64'h0);

        // Reset with a read in flight; requests during reset are dropped
        wr(16'h0012, 1, 64'h0000_00F0_0000_00F0);
        wr(16'h000C, 1, 64'h5555_AAAA_5555_AAAA);
        idle(4);
        drive(1, 0, 16'h000A, 1, 9'h055, 64'h0, 0, 0, 64'h0, 0);
        SoftReset = 1'b1;
        drive(1, 0, 16'h000A, 1, 9'h056, 64'h0, 0, 0, 64'h0, 0);
        chk("flush_rd_valid", 64'(bus.c2_mmio_rd_valid), 64'h0);
        chk("flush_tid",      64'(bus.c2_hdr_tid), 64'h0);
        chk("flush_data",     bus.c2_data, 64'h0);
        chk("flush_csr_ctrl", csr_ctrl, 64'h0);
        idle(1);
        SoftReset = 1'b0;
        idle(5);
        rd_chk(16'h0010, 1, 9'h060, 64'h0);
        rd_chk(16'h000A, 1, 9'h061, 64'h0);
        rd_chk(16'h000C, 1, 9'h062, 64'h0);
        rd_chk(16'h0012, 1, 9'h063, 64'h0);
        rd_chk(16'h0040, 1, 9'h064, 64'h0);
        rd_chk(16'h000B, 1, 9'h065, 64'h0);

        // Randomized traffic against the reference model
        pulse_reset();
        m_reset();
        for (int k = 0; k < 300; k++) begin
            bit          r, w, e, l8;
            logic [15:0] dw;
            logic [63:0] d, x;
            logic [8:0]  t;
            r  = ($urandom_range(0, 99) < 45);
            w  = !r && ($urandom_range(0, 99) < 55);
            e  = ($urandom_range(0, 7) == 0);
            l8 = $urandom_range(0, 1) == 1;
            dw = ($urandom_range(0, 9) == 0) ? 16'(16'h40 + $urandom_range(0, 15))
                                            : 16'($urandom_range(0, 19));
            if (r && (dw == 16'h000E || dw == 16'h000F)) dw = 16'h000A;
            if (dw == 16'h0010 && $urandom_range(0, 3) != 0) begin
                d = 64'($urandom_range(0, 3));
            end else begin
                d = {32'($urandom), 32'($urandom)};
            end
            t = 9'($urandom);
            x = m_read(dw, l8);
            drive(r, w, dw, l8, t, d, e, 1, x, 0);
            m_apply(r, w, dw, l8, d, e);
        end
        idle(6);
        chk("csr_ctrl_random", csr_ctrl, m_ctrl);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
